// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller: 8N1 / 8E1 / 8O1 framing with a one-byte holding register
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous reset, active low
//   tick        baud enable, one CLK pulse per bit period
//   data_in     byte to transmit
//   data_valid  byte offered on data_in
//   ParEN       1 = append parity bit
//   ParTYP      0 = even parity, 1 = odd parity
//   ready       a byte can be accepted this cycle
//   TX_OUT      serial line, registered, idle high
//   busy        frame in progress
//   frame_done  one CLK pulse at the end of the stop bit
//
// Build option: UART_TX_HOLD_REG_EN
//   defined   - a byte can be accepted during a frame and follows the current
//               stop bit directly, with no idle bit between frames
//   undefined - a byte is accepted only while idle

module uart_tx_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       ParEN,
    input  logic       ParTYP,
    output logic       ready,
    output logic       TX_OUT,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

`ifdef UART_TX_HOLD_REG_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    state_t     state;
    logic [7:0] hold_data;
    logic       hold_par_en;
    logic       hold_par_typ;
    logic       pending;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       par_en_q;
    logic       par_bit_q;
    logic       accept;
    logic       start_frame;

    assign ready  = HOLD_EN ? !pending : ((state == IDLE) && !pending);
    assign accept = data_valid && ready;
    assign busy   = (state != IDLE);

    // A new frame starts from IDLE, or straight out of STOP when back-to-back
    // frames are enabled. Acceptance and start are mutually exclusive because
    // one needs pending=0 and the other pending=1.
    assign start_frame = tick && pending &&
                         ((state == IDLE) || (HOLD_EN && (state == STOP)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            hold_data    <= 8'h00;
            hold_par_en  <= 1'b0;
            hold_par_typ <= 1'b0;
            pending      <= 1'b0;
            shift_reg    <= 8'h00;
            bit_idx      <= 3'd0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            TX_OUT       <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= tick && (state == STOP);

            if (accept) begin
                hold_data    <= data_in;
                hold_par_en  <= ParEN;
                hold_par_typ <= ParTYP;
                pending      <= 1'b1;
            end

            if (start_frame) begin
                // Parity is resolved at load time so later ParEN/ParTYP
                // changes cannot reach the frame in flight.
                state     <= START;
                shift_reg <= hold_data;
                par_en_q  <= hold_par_en;
                par_bit_q <= (^hold_data) ^ hold_par_typ;
                bit_idx   <= 3'd0;
                pending   <= 1'b0;
                TX_OUT    <= 1'b0;
            end else if (tick) begin
                // TX_OUT is loaded with the level of the state being entered.
                case (state)
                    IDLE: begin
                        TX_OUT <= 1'b1;
                    end
                    START: begin
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        TX_OUT  <= shift_reg[0];
                    end
                    DATA: begin
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state  <= par_en_q ? PARITY : STOP;
                            TX_OUT <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            TX_OUT <= shift_reg[1];
                        end
                    end
                    PARITY: begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                    STOP: begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl

module tb_uart_tx_ctrl;

`ifdef UART_TX_HOLD_REG_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       ParEN = 1'b0;
    logic       ParTYP = 1'b0;
    logic       ready;
    logic       TX_OUT;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_count = 0;

    uart_tx_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .tick       (tick),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ParEN      (ParEN),
        .ParTYP     (ParTYP),
        .ready      (ready),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (frame_done) fd_count <= fd_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // One bit period: 15 quiet cycles then a single tick; returns at the
    // falling edge after the tick edge so outputs can be sampled.
    task automatic tick_period();
        repeat (15) @(negedge CLK);
        tick = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        data_in    = d;
        ParEN      = pe;
        ParTYP     = pt;
        data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
    endtask

    // exp_bits[0] is the start bit, exp_bits[nbits-1] the stop bit.
    task automatic run_frame(input string tag, input logic [10:0] exp_bits, input int nbits);
        int fd0;
        fd0 = fd_count;
        for (int i = 0; i < nbits; i++) begin
            tick_period();
            check($sformatf("%s_bit%0d", tag, i), TX_OUT, exp_bits[i]);
            check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            check($sformatf("%s_ready%0d", tag, i), ready, HOLD_EN);
        end
        tick_period();
        check({tag, "_fd_hi"}, frame_done, 1'b1);
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_tx"}, TX_OUT, 1'b1);
        check({tag, "_end_ready"}, ready, 1'b1);
        @(negedge CLK);
        check({tag, "_fd_lo"}, frame_done, 1'b0);
        check({tag, "_fd_count"}, fd_count - fd0, 1);
    endtask

    initial begin
        logic tx_high;
        int   fd0;
        logic [19:0] seq;

        // Reset state
        @(negedge CLK);
        check("rst_tx", TX_OUT, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        RST = 1'b1;
        @(negedge CLK);

        // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
        send_byte(8'hA5, 1'b0, 1'b0);
        check("a5_ready_pending", ready, 1'b0);
        run_frame("a5", 11'h34A, 10);

        // 0x01 even parity -> parity 1; odd -> parity 0
        send_byte(8'h01, 1'b1, 1'b0);
        run_frame("p_even", 11'h602, 11);
        send_byte(8'h01, 1'b1, 1'b1);
        run_frame("p_odd", 11'h402, 11);

        // ParEN raised after acceptance must not add a parity bit
        send_byte(8'h3C, 1'b0, 1'b0);
        ParEN = 1'b1;
        run_frame("3c_paren", 11'h278, 10);
        ParEN = 1'b0;

        // data_valid ignored while ready=0 (byte pending)
        send_byte(8'h55, 1'b0, 1'b0);
        @(negedge CLK);
        check("blk_ready", ready, 1'b0);
        data_in    = 8'hFF;
        data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        run_frame("blk_55", 11'h2AA, 10);
        tick_period();
        check("blk_no_second", busy, 1'b0);

        // Acceptance and tick in the same idle cycle: start on the next tick
        @(negedge CLK);
        data_in    = 8'hA5;
        data_valid = 1'b1;
        tick       = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        tick       = 1'b0;
        check("same_busy", busy, 1'b0);
        check("same_tx", TX_OUT, 1'b1);
        run_frame("same", 11'h34A, 10);

        // Reset during DATA bit 4 of 0xA5 (bit 4 = 0)
        send_byte(8'hA5, 1'b0, 1'b0);
        repeat (6) tick_period();
        check("mid_bit4", TX_OUT, 1'b0);
        check("mid_busy", busy, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        check("arst_tx", TX_OUT, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", ready, 1'b1);
        check("arst_fd", frame_done, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        fd0     = fd_count;
        tx_high = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick_period();
            tx_high = tx_high & TX_OUT & !busy;
        end
        check("post_rst_quiet", tx_high, 1'b1);
        check("post_rst_fd", fd_count - fd0, 0);

`ifdef UART_TX_HOLD_REG_EN
        // Back-to-back 0x55 then 0xAA: 20 consecutive bit periods
        seq = {10'h354, 10'h2AA};
        send_byte(8'h55, 1'b0, 1'b0);
        fd0 = fd_count;
        for (int i = 0; i < 20; i++) begin
            tick_period();
            check($sformatf("b2b_bit%0d", i), TX_OUT, seq[i]);
            check($sformatf("b2b_busy%0d", i), busy, 1'b1);
            if (i == 10) check("b2b_fd_mid", frame_done, 1'b1);
            if (i == 2) begin
                check("b2b_ready", ready, 1'b1);
                send_byte(8'hAA, 1'b0, 1'b0);
                check("b2b_ready_full", ready, 1'b0);
            end
        end
        tick_period();
        check("b2b_fd_end", frame_done, 1'b1);
        check("b2b_end_busy", busy, 1'b0);
        @(negedge CLK);
        check("b2b_fd_count", fd_count - fd0, 2);
`else
        seq = 20'h0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
